// File: rtl/fir_filter_core_param_if.sv
// Sample-in / result-out handshake bundle for the parameterised FIR core.
interface fir_filter_core_param_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/fir_filter_core_param.sv
// Sequential single-MAC FIR: one sample in, TAPS multiply-accumulate cycles,
// then a held result with optional shift/saturation or a straight bypass.
module fir_filter_core_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 4,
  parameter int OUT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  fir_filter_core_param_if.slave     bus,
  input  logic                       coef_we,
  input  logic [$clog2(TAPS)-1:0]    coef_addr,
  input  logic signed [COEF_W-1:0]   coef_data,
  input  logic [4:0]                 shift,
  input  logic                       sat_en,
  input  logic                       bypass,
  output logic                       busy
);

  localparam int KW    = $clog2(TAPS);
  localparam int ACC_W = DATA_W + COEF_W + KW;
  localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
  localparam logic signed [CMP_W-1:0] OMAX =
    {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] OMIN = ~OMAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_e;

  state_e state_q, state_d;

  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [KW-1:0]            k_q, k_d;
  logic [4:0]               shift_q;
  logic                     sat_q;
  logic                     byp_q;

  logic                     accept;
  logic                     coef_wr;
  logic signed [ACC_W-1:0]  prod;
  logic signed [ACC_W-1:0]  scaled;
  logic signed [CMP_W-1:0]  s_ext;
  logic signed [OUT_W-1:0]  result;

  assign accept  = bus.in_valid & (state_q == IDLE);
  assign coef_wr = coef_we & (state_q == IDLE) & (32'(coef_addr) < 32'(TAPS));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.in_valid) state_d = bypass ? OUT : MAC;
      MAC:  if (k_q == KW'(TAPS - 1)) state_d = OUT;
      OUT:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == OUT);
    busy          = (state_q != IDLE);
    bus.out_data  = (state_q == OUT) ? result : '0;
  end

  // Accumulator and tap index
  always_comb begin
    prod  = ACC_W'(x_q[k_q]) * ACC_W'(c_q[k_q]);
    acc_d = acc_q;
    k_d   = k_q;
    if (accept) begin
      acc_d = '0;
      k_d   = '0;
    end else if (state_q == MAC) begin
      acc_d = acc_q + prod;
      k_d   = k_q + KW'(1);
    end
  end

  // Result formatting from latched controls, so it stays fixed while held
  always_comb begin
    scaled = acc_q >>> shift_q;
    s_ext  = CMP_W'(scaled);
    result = s_ext[OUT_W-1:0];
    if (byp_q) begin
      result = OUT_W'(x_q[0]);
    end else if (sat_q) begin
      if (s_ext > OMAX)      result = OMAX[OUT_W-1:0];
      else if (s_ext < OMIN) result = OMIN[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= (i == 0) ? COEF_W'(1) : '0;
      end
      acc_q   <= '0;
      k_q     <= '0;
      shift_q <= '0;
      sat_q   <= 1'b0;
      byp_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      k_q   <= k_d;
      if (accept) begin
        for (int unsigned i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
        x_q[0]  <= bus.in_data;
        shift_q <= shift;
        sat_q   <= sat_en;
        byp_q   <= bypass;
      end
      if (coef_wr) c_q[coef_addr] <= coef_data;
    end
  end

endmodule

// File: doc/fir_filter_core_param.md
FIR_FILTER_CORE_PARAM -- requirements
Module: fir_filter_core_param

Interface
REQ-001 Parameter DATA_W, default 8: signed input sample width.
REQ-002 Parameter COEF_W, default 8: signed coefficient width.
REQ-003 Parameter TAPS, default 4, legal 2..16: filter length.
REQ-004 Parameter OUT_W, default 8: signed output width.
REQ-005 Derived ACC_W = DATA_W+COEF_W+clog2(TAPS), signed accumulator width.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 in_valid  in  1  input sample present.
REQ-009 in_ready  out  1  core can accept a sample.
REQ-010 in_data  in  DATA_W  signed input sample.
REQ-011 out_valid  out  1  filtered result present.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 out_data  out  OUT_W  signed filtered result.
REQ-014 coef_we  in  1  coefficient write strobe.
REQ-015 coef_addr  in  clog2(TAPS)  coefficient index.
REQ-016 coef_data  in  COEF_W  signed coefficient value.
REQ-017 shift  in  5  arithmetic right-shift applied to accumulator.
REQ-018 sat_en  in  1  1 = saturate output, 0 = truncate.
REQ-019 bypass  in  1  1 = pass sample straight through, no MAC.
REQ-020 busy  out  1  high in MAC or OUT state.

Function
REQ-021 FSM states IDLE, MAC, OUT; in_ready SHALL be 1 only in IDLE.
REQ-022 Accept = in_valid & in_ready; on accept the delay line SHALL shift (x[k]<=x[k-1]), x[0]<=in_data, and shift/sat_en/bypass SHALL be latched.
REQ-023 Accept with bypass=0: acc<=0, k<=0, go MAC; each MAC cycle acc+=x[k]*c[k], k++; after k=TAPS-1 go OUT (exactly TAPS MAC cycles).
REQ-024 Accept with bypass=1: go directly to OUT with out_data = latched in_data sign-extended/truncated to OUT_W; delay line still updated.
REQ-025 Latency: accept at edge t -> out_valid high after edge t+TAPS+1 (bypass: after edge t+1).
REQ-026 Scaling: s = acc >>> shift (sign fill; shift >= ACC_W gives 0 or -1).
REQ-027 sat_en=1: out_data = clamp(s, -2^(OUT_W-1), 2^(OUT_W-1)-1); sat_en=0: out_data = s[OUT_W-1:0].
REQ-028 In OUT, out_valid=1 and out_data SHALL stay stable until out_ready=1; on that handshake go IDLE.
REQ-029 No input accepted in the OUT-exit cycle; max throughput one sample per TAPS+2 cycles.
REQ-030 Coefficient write c[coef_addr]<=coef_data SHALL occur only when coef_we=1, state IDLE and coef_addr<TAPS; otherwise ignored.
REQ-031 Coefficient write and sample accept in the same IDLE cycle: both take effect; new coefficient used by that sample's MAC.
REQ-032 Changes of shift/sat_en/bypass while busy SHALL not affect the in-flight result.
REQ-033 Outside OUT, out_valid=0 and out_data=0.

Reset
REQ-034 rst=1 at an edge SHALL: state IDLE, delay line all 0, acc 0, k 0, c[0]=1, c[1..TAPS-1]=0 (identity filter).
REQ-035 Reset values: in_ready=1 (once rst deasserted), out_valid=0, out_data=0, busy=0.
REQ-036 Reset mid-MAC or mid-OUT SHALL abort; in-flight result discarded, never presented.

Verification (TAPS=4, DATA_W=COEF_W=OUT_W=8 unless stated)
REQ-037 After reset, shift=0, sat_en=1: accept 5 -> out_valid after 5 edges, out_data=5.
REQ-038 Write c=1,1,1,1; feed 10,20,30,40 -> outputs 10,30,60,100 in order.
REQ-039 c all 127 except c[1..3]=0, input 127: sat_en=1 -> 127; sat_en=0 -> 16129 truncated = 1; shift=7, sat_en=1 -> 126.
REQ-040 out_ready=0 for 10 cycles in OUT -> out_valid, out_data stable, in_ready=0, coef writes ignored.
REQ-041 bypass=1, input -7 -> out_valid after 1 edge, out_data=-7; next non-bypass identity sample uses updated delay line.
REQ-042 rst pulse during MAC -> next cycle out_valid=0, in_ready=1; then accept 3 -> out_data=3.
